// File: rtl/memcard_sync.sv
// memcard_sync: synchronous memory-card slot model, byte storage on CDD[7:0].
// Optional MEMCARD_WP_EN adds a registered write-protect switch input WP_SW.
module memcard_sync #(
    parameter int          ADDR_W    = 11,
    parameter logic [7:0]  ATTR_BYTE = 8'h00,
    parameter logic [7:0]  INIT_BYTE = 8'hFF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [23:0] CDA,
    input  logic [15:0] CDD_IN,
    output logic [15:0] CDD_OUT,
    output logic        CDD_OE,
    input  logic        nCRDC,
    input  logic        nCRDO,
    input  logic        nWE,
    input  logic        nREG,
`ifdef MEMCARD_WP_EN
    input  logic        WP_SW,
`endif
    output logic        nCD1,
    output logic        nCD2,
    output logic        nWP
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Non-volatile backing store; only the power-up image is preset.
    logic [7:0]        mem [0:DEPTH-1] = '{default: INIT_BYTE};

    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              we_q;
    logic              wr_commit;
    logic [7:0]        rd_byte;
    logic              unused_bits;

    // Upper address lines and the data high byte are not decoded.
    assign addr        = CDA[ADDR_W-1:0];
    assign unused_bits = ^{CDA[23:ADDR_W], CDD_IN[15:8]};

    // Card is permanently inserted.
    assign nCD1 = 1'b0;
    assign nCD2 = 1'b0;

`ifdef MEMCARD_WP_EN
    logic wp_q;

    // Write-protect switch is sampled; protected coming out of reset.
    always_ff @(posedge CLK) begin
        if (RESET) wp_q <= 1'b1;
        else       wp_q <= WP_SW;
    end

    assign nWP = wp_q;
`else
    assign nWP = 1'b0;
`endif

    // Read request and the falling-edge-qualified write commit.
    always_comb begin
        rd        = !nCRDC && !nCRDO && nWE;
        wr_commit = !RESET && !nWE && we_q && !nCRDC && nREG && !nWP;
        rd_byte   = nREG ? mem[addr] : ATTR_BYTE;
    end

    // nWE history so a held-low strobe commits only once.
    always_ff @(posedge CLK) begin
        if (RESET) we_q <= 1'b1;
        else       we_q <= nWE;
    end

    // Storage write port.
    always_ff @(posedge CLK) begin
        if (wr_commit) mem[addr] <= CDD_IN[7:0];
    end

    // Read data path: one-clock latency, holds last data when idle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            CDD_OE  <= 1'b0;
            CDD_OUT <= 16'hFFFF;
        end else if (rd) begin
            CDD_OE  <= 1'b1;
            CDD_OUT <= {8'hFF, rd_byte};
        end else begin
            CDD_OE  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memcard_sync.sv
// tb_memcard_sync: randomized scoreboard bench for memcard_sync.
// Expected bus responses come from a byte-array model of the card.
module tb_memcard_sync;

    typedef struct {
        logic        oe;
        logic [15:0] out;
        logic        wp;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [23:0] CDA;
    logic [15:0] CDD_IN;
    logic [15:0] CDD_OUT;
    logic        CDD_OE;
    logic        nCRDC, nCRDO, nWE, nREG;
    logic        nCD1, nCD2, nWP;
`ifdef MEMCARD_WP_EN
    logic        WP_SW;
`endif

    int total = 0;
    int bad   = 0;

    exp_t        q[$];
    logic [7:0]  m [0:2047];
    logic        prev_nwe;
    logic [15:0] last_out;
    logic        wp_m;
    bit          wp_sw_m;

    memcard_sync dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .CDA    (CDA),
        .CDD_IN (CDD_IN),
        .CDD_OUT(CDD_OUT),
        .CDD_OE (CDD_OE),
        .nCRDC  (nCRDC),
        .nCRDO  (nCRDO),
        .nWE    (nWE),
        .nREG   (nREG),
`ifdef MEMCARD_WP_EN
        .WP_SW  (WP_SW),
`endif
        .nCD1   (nCD1),
        .nCD2   (nCD2),
        .nWP    (nWP)
    );

    always #5 CLK = ~CLK;

    // One bus cycle: apply inputs, predict the result of the coming edge.
    task automatic drive(input bit rst, input logic [23:0] a,
                         input logic [7:0] d, input bit crdc,
                         input bit crdo, input bit we, input bit rg);
        exp_t e;
        int   idx;
        bit   rdq, cmt;
        RESET  = rst;
        CDA    = a;
        CDD_IN = {8'h5C, d};
        nCRDC  = crdc;
        nCRDO  = crdo;
        nWE    = we;
        nREG   = rg;
`ifdef MEMCARD_WP_EN
        WP_SW  = wp_sw_m;
`endif
        idx = int'(a) % 2048;
        rdq = !crdc && !crdo && we;
        cmt = !rst && !we && prev_nwe && !crdc && rg && !wp_m;
        if (rst) begin
            last_out = 16'hFFFF;
            e.oe = 1'b0;
        end else if (rdq) begin
            last_out = {8'hFF, rg ? m[idx] : 8'h00};
            e.oe = 1'b1;
        end else begin
            e.oe = 1'b0;
        end
        e.out = last_out;
        if (cmt) m[idx] = d;
        prev_nwe = rst ? 1'b1 : we;
`ifdef MEMCARD_WP_EN
        wp_m = rst ? 1'b1 : wp_sw_m;
`else
        wp_m = 1'b0;
`endif
        e.wp = wp_m;
        q.push_back(e);
        @(negedge CLK);
    endtask

    task automatic idle();
        drive(0, 24'h0, 8'h00, 1, 1, 1, 1);
    endtask

    task automatic wr(input logic [23:0] a, input logic [7:0] d,
                      input bit rg);
        drive(0, a, d, 0, 1, 0, rg);
    endtask

    task automatic rdc(input logic [23:0] a, input bit rg);
        drive(0, a, 8'h00, 0, 0, 1, rg);
    endtask

    // Monitor: after every edge compare the card's bus against the model.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (CDD_OE !== e.oe) begin
                bad++;
                $display("FAIL oe t=%0t got=%b exp=%b", $time, CDD_OE, e.oe);
            end
            total++;
            if (CDD_OUT !== e.out) begin
                bad++;
                $display("FAIL out t=%0t got=%h exp=%h",
                         $time, CDD_OUT, e.out);
            end
            total++;
            if ({nCD1, nCD2, nWP} !== {2'b00, e.wp}) begin
                bad++;
                $display("FAIL status t=%0t got=%b exp=%b",
                         $time, {nCD1, nCD2, nWP}, {2'b00, e.wp});
            end
        end
    end

    initial begin
        logic [23:0] r;
        for (int i = 0; i < 2048; i++) m[i] = 8'hFF;
        prev_nwe = 1'b1;
        last_out = 16'hFFFF;
        wp_m     = 1'b1;
        wp_sw_m  = 1'b0;

        drive(1, 24'h0, 8'h00, 1, 1, 1, 1);
        drive(1, 24'h0, 8'h00, 1, 1, 1, 1);
        idle();

        wr(24'h000123, 8'h5A, 1);
        idle();
        rdc(24'h000123, 1);
        idle();

        wr(24'h000800, 8'hC3, 1);
        rdc(24'h000000, 1);
        idle();

        wr(24'h000040, 8'h11, 1);
        wr(24'h000040, 8'h22, 1);
        wr(24'h000040, 8'h33, 1);
        wr(24'h000040, 8'h33, 1);
        wr(24'h000040, 8'h33, 1);
        rdc(24'h000040, 1);
        idle();

        wr(24'h000010, 8'h77, 0);
        idle();
        rdc(24'h000010, 0);
        rdc(24'h000010, 1);
        idle();

        drive(1, 24'h000050, 8'h99, 0, 1, 0, 1);
        rdc(24'h000050, 1);
        drive(1, 24'h000123, 8'h00, 0, 0, 1, 1);
        rdc(24'h000123, 1);
        idle();

        drive(0, 24'h000060, 8'h6B, 0, 0, 0, 1);
        rdc(24'h000060, 1);
        drive(0, 24'h000061, 8'h01, 1, 1, 0, 1);
        rdc(24'h000061, 1);
        idle();

`ifdef MEMCARD_WP_EN
        wp_sw_m = 1'b1;
        idle();
        wr(24'h000020, 8'hAA, 1);
        rdc(24'h000020, 1);
        wp_sw_m = 1'b0;
        idle();
        wr(24'h000020, 8'hAA, 1);
        rdc(24'h000020, 1);
        idle();
`endif

        for (int i = 0; i < 3000; i++) begin
            r = 24'($urandom()) & 24'hFFF81F;
`ifdef MEMCARD_WP_EN
            if ($urandom_range(0, 40) == 0) wp_sw_m = ~wp_sw_m;
`endif
            drive($urandom_range(0, 60) == 0, r, 8'($urandom()),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 6) != 0);
        end

        idle();
        @(negedge CLK);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
